axi_w_allocator: RTL and testbench

//  Per-target-port write-data router. Sits upstream of the B-channel allocator: it sees the same

---
 rtl/axi_node_pkg.sv | 26 ++
 rtl/axi_w_cmd_fifo.sv | 57 +++++
 rtl/axi_w_allocator.sv | 113 +++++++++++
 tb/tb_axi_w_allocator.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
// Shared types for the AXI node write path: the routed-command record and the W allocator states.
// No logic here; the defaults below set the field widths of w_cmd_t.
package axi_node_pkg;

    localparam int DEF_N_INIT_PORT = 7;
    localparam int DEF_AXI_DATA_W  = 64;
    localparam int DEF_AXI_USER_W  = 6;
    localparam int DEF_AXI_ID_IN   = 16;
    localparam int DEF_CMD_DEPTH   = 4;

    typedef struct packed {
        logic [DEF_N_INIT_PORT-1:0] dest;
        logic                       error;
        logic [DEF_AXI_ID_IN-1:0]   id;
        logic [DEF_AXI_USER_W-1:0]  user;
    } w_cmd_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_FWD,
        W_SINK,
        W_ERR_REQ,
        W_ERR_WAIT
    } w_state_e;

endpackage

// File: rtl/axi_w_cmd_fifo.sv
// Generic register FIFO; an entry is visible at data_o the cycle after its push.
// Pushes are ignored when full (even with a concurrent pop), pops are ignored when empty.
module axi_w_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_w_allocator.sv
// Steers W beats to the init port named by the head AW command; sinks decode-error bursts and then
// requests one DECERR B. Beats flow from the cycle after push plus one IDLE bubble per burst.
module axi_w_allocator
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT = DEF_N_INIT_PORT,
    parameter int AXI_DATA_W  = DEF_AXI_DATA_W,
    parameter int AXI_USER_W  = DEF_AXI_USER_W,
    parameter int AXI_ID_IN   = DEF_AXI_ID_IN,
    parameter int CMD_DEPTH   = DEF_CMD_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [N_INIT_PORT-1:0]  cmd_dest_i,
    input  logic                    cmd_error_i,
    input  logic [AXI_ID_IN-1:0]    cmd_id_i,
    input  logic [AXI_USER_W-1:0]   cmd_user_i,
    input  logic [AXI_DATA_W-1:0]   wdata_i,
    input  logic [AXI_DATA_W/8-1:0] wstrb_i,
    input  logic [AXI_USER_W-1:0]   wuser_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [AXI_DATA_W-1:0]   wdata_o,
    output logic [AXI_DATA_W/8-1:0] wstrb_o,
    output logic [AXI_USER_W-1:0]   wuser_o,
    output logic                    wlast_o,
    output logic [N_INIT_PORT-1:0]  wvalid_o,
    input  logic [N_INIT_PORT-1:0]  wready_i,
    output logic                    incr_req_o,
    input  logic                    full_counter_i,
    output logic                    sample_awdata_info_o,
    output logic                    error_req_o,
    input  logic                    error_gnt_i,
    output logic [AXI_ID_IN-1:0]    error_id_o,
    output logic [AXI_USER_W-1:0]   error_user_o
);

    w_state_e                  state_q;
    w_cmd_t                    cmd_in, head;
    logic [$bits(w_cmd_t)-1:0] head_raw;
    logic                      fifo_full, fifo_empty, push, pop;

    // Gating with rst_n keeps the push side silent while reset is held.
    assign cmd_ready_o = rst_n & ~fifo_full & ~full_counter_i;
    assign push        = cmd_valid_i & cmd_ready_o;
    assign incr_req_o  = push & ~cmd_error_i;

    assign cmd_in = '{dest: cmd_dest_i, error: cmd_error_i, id: cmd_id_i, user: cmd_user_i};
    assign head   = w_cmd_t'(head_raw);

    axi_w_cmd_fifo #(
        .WIDTH ($bits(w_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (cmd_in),
        .pop_i   (pop),
        .data_o  (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wdata_o      = wdata_i;
    assign wstrb_o      = wstrb_i;
    assign wuser_o      = wuser_i;
    assign wlast_o      = wlast_i;
    assign error_id_o   = head.id;
    assign error_user_o = head.user;

    always_comb begin
        wvalid_o             = '0;
        wready_o             = 1'b0;
        sample_awdata_info_o = 1'b0;
        error_req_o          = 1'b0;
        pop                  = 1'b0;
        case (state_q)
            W_FWD: begin
                wvalid_o = head.dest & {N_INIT_PORT{wvalid_i}};
                wready_o = |(wready_i & head.dest);
                pop      = wvalid_i & wready_o & wlast_i;
            end
            W_SINK: begin
                wready_o             = 1'b1;
                sample_awdata_info_o = wvalid_i & wlast_i;
            end
            // The request drops in the very cycle the grant appears.
            W_ERR_REQ:  error_req_o = ~error_gnt_i;
            W_ERR_WAIT: pop         = ~error_gnt_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= W_IDLE;
        end else begin
            case (state_q)
                W_IDLE:     if (!fifo_empty) state_q <= head.error ? W_SINK : W_FWD;
                W_FWD:      if (wvalid_i && wready_o && wlast_i) state_q <= W_IDLE;
                W_SINK:     if (wvalid_i && wlast_i) state_q <= W_ERR_REQ;
                W_ERR_REQ:  if (error_gnt_i) state_q <= W_ERR_WAIT;
                W_ERR_WAIT: if (!error_gnt_i) state_q <= W_IDLE;
                default:    state_q <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_w_allocator.sv
// Directed bench for the W allocator: routing, backpressure, decode-error sinking, FIFO full,
// ordering behind a pending DECERR and mid-burst reset.
module tb_axi_w_allocator;

    localparam int N  = 7;
    localparam int DW = 64;
    localparam int UW = 6;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [N-1:0]  cmd_dest_i = '0;
    logic          cmd_error_i = 1'b0;
    logic [IW-1:0] cmd_id_i = '0;
    logic [UW-1:0] cmd_user_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [DW/8-1:0] wstrb_i = '0;
    logic [UW-1:0] wuser_i = '0;
    logic          wlast_i = 1'b0;
    logic          wvalid_i = 1'b0;
    logic          wready_o;
    logic [DW-1:0] wdata_o;
    logic [DW/8-1:0] wstrb_o;
    logic [UW-1:0] wuser_o;
    logic          wlast_o;
    logic [N-1:0]  wvalid_o;
    logic [N-1:0]  wready_i = '1;
    logic          incr_req_o;
    logic          full_counter_i = 1'b0;
    logic          sample_awdata_info_o;
    logic          error_req_o;
    logic          error_gnt_i = 1'b0;
    logic [IW-1:0] error_id_o;
    logic [UW-1:0] error_user_o;

    int n_vec = 0;
    int n_err = 0;

    axi_w_allocator dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_dest_i(cmd_dest_i),
        .cmd_error_i(cmd_error_i), .cmd_id_i(cmd_id_i), .cmd_user_i(cmd_user_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wuser_i(wuser_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wuser_o(wuser_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .incr_req_o(incr_req_o), .full_counter_i(full_counter_i),
        .sample_awdata_info_o(sample_awdata_info_o),
        .error_req_o(error_req_o), .error_gnt_i(error_gnt_i),
        .error_id_o(error_id_o), .error_user_o(error_user_o)
    );

    always #5 clk = ~clk;

    // Event log sampled on the falling edge, away from the active edge.
    int incr_cnt = 0, samp_cnt = 0, bad_samp = 0, viol_cnt = 0, acc_cnt = 0;
    logic [DW-1:0] del_q [$];
    logic [N-1:0]  wv_q  [$];

    always @(negedge clk) begin
        if (incr_req_o) incr_cnt++;
        if (sample_awdata_info_o) samp_cnt++;
        if (sample_awdata_info_o && !(wvalid_i && wready_o && wlast_i)) bad_samp++;
        if (error_req_o && error_gnt_i) viol_cnt++;
        if (wvalid_i && wready_o) acc_cnt++;
        if (|(wvalid_o & wready_i)) del_q.push_back(wdata_o);
        if (wvalid_o != '0) wv_q.push_back(wvalid_o);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [N-1:0] dest, input logic err,
                            input logic [IW-1:0] id, input logic [UW-1:0] user);
        cmd_dest_i = dest; cmd_error_i = err; cmd_id_i = id; cmd_user_i = user;
        cmd_valid_i = 1'b1;
        step();
        cmd_valid_i = 1'b0;
    endtask

    // Presents consecutive beats base, base+1, ... until n are accepted or the budget runs out.
    task automatic drive_burst(input int n, input logic [DW-1:0] base, input int budget,
                               output int got);
        int k;
        int t;
        k = 0;
        t = 0;
        while (k < n && t < budget) begin
            wvalid_i = 1'b1;
            wdata_i  = base + DW'(k);
            wstrb_i  = '1;
            wuser_i  = UW'(k);
            wlast_i  = (k == n - 1);
            @(negedge clk);
            if (wready_o) k++;
            step();
            t++;
        end
        wvalid_i = 1'b0;
        wlast_i  = 1'b0;
        got = k;
    endtask

    task automatic test_reset();
        cmd_valid_i = 1'b1; cmd_dest_i = 7'h01;
        wvalid_i = 1'b1; wlast_i = 1'b1;
        wdata_i = 64'hDEAD_BEEF_0123_4567; wstrb_i = 8'hA5; wuser_i = 6'h15;
        #1;
        n_vec++; if (cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %b exp 0", cmd_ready_o); end
        n_vec++; if (wready_o !== 1'b0) begin n_err++; $display("FAIL reset_wready: got %b exp 0", wready_o); end
        n_vec++; if (wvalid_o !== 7'h00) begin n_err++; $display("FAIL reset_wvalid: got %h exp 00", wvalid_o); end
        n_vec++; if ({incr_req_o, sample_awdata_info_o, error_req_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_pulses: got %b exp 000", {incr_req_o, sample_awdata_info_o, error_req_o}); end
        n_vec++; if ({wdata_o, wstrb_o, wuser_o, wlast_o} !== {64'hDEAD_BEEF_0123_4567, 8'hA5, 6'h15, 1'b1}) begin
            n_err++; $display("FAIL reset_wbroadcast: got %h/%h/%h/%b", wdata_o, wstrb_o, wuser_o, wlast_o); end
        step(); step();
        cmd_valid_i = 1'b0; wvalid_i = 1'b0; wlast_i = 1'b0;
        rst_n = 1'b1;
        #1;
        n_vec++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_cmd_ready: got %b exp 1", cmd_ready_o); end
        step();
    endtask

    task automatic test_route();
        int i0, w0, inc0, got;
        i0 = del_q.size(); w0 = wv_q.size(); inc0 = incr_cnt;
        cmd_dest_i = 7'b0000100; cmd_error_i = 1'b0; cmd_id_i = 16'd3; cmd_user_i = 6'd1;
        cmd_valid_i = 1'b1;
        #1;
        n_vec++; if (incr_req_o !== 1'b1) begin n_err++; $display("FAIL route_incr: got %b exp 1", incr_req_o); end
        step();
        cmd_valid_i = 1'b0;
        drive_burst(4, 64'h100, 20, got);
        n_vec++; if (got !== 4) begin n_err++; $display("FAIL route_accepted: got %0d exp 4", got); end
        n_vec++; if (del_q.size() - i0 !== 4) begin n_err++; $display("FAIL route_delivered: got %0d exp 4", del_q.size() - i0); end
        for (int k = 0; k < 4 && i0 + k < del_q.size(); k++) begin
            n_vec++; if (del_q[i0+k] !== 64'h100 + DW'(k)) begin
                n_err++; $display("FAIL route_data%0d: got %h exp %h", k, del_q[i0+k], 64'h100 + DW'(k)); end
        end
        n_vec++; if (wv_q.size() - w0 !== 4) begin n_err++; $display("FAIL route_valid_cycles: got %0d exp 4", wv_q.size() - w0); end
        for (int k = w0; k < wv_q.size(); k++) begin
            n_vec++; if (wv_q[k] !== 7'b0000100) begin n_err++; $display("FAIL route_port: got %b exp 0000100", wv_q[k]); end
        end
        n_vec++; if (incr_cnt - inc0 !== 1) begin n_err++; $display("FAIL route_incr_count: got %0d exp 1", incr_cnt - inc0); end
        wvalid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (wready_o !== 1'b0) begin n_err++; $display("FAIL route_empty_wready: got %b exp 0", wready_o); end
            step();
        end
        wvalid_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int i0, got;
        i0 = del_q.size();
        push_cmd(7'b0000010, 1'b0, 16'd4, 6'd2);
        fork
            drive_burst(6, 64'h200, 40, got);
            begin
                step(); step(); step();
                wready_i = 7'b1111101;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    n_vec++; if (wready_o !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d_wready: got %b exp 0", c, wready_o); end
                    step();
                end
                wready_i = '1;
            end
        join
        n_vec++; if (got !== 6) begin n_err++; $display("FAIL bp_accepted: got %0d exp 6", got); end
        n_vec++; if (del_q.size() - i0 !== 6) begin n_err++; $display("FAIL bp_delivered: got %0d exp 6", del_q.size() - i0); end
        for (int k = 0; k < 6 && i0 + k < del_q.size(); k++) begin
            n_vec++; if (del_q[i0+k] !== 64'h200 + DW'(k)) begin
                n_err++; $display("FAIL bp_data%0d: got %h exp %h", k, del_q[i0+k], 64'h200 + DW'(k)); end
        end
        step();
    endtask

    task automatic test_decerr();
        int i0, w0, inc0, s0, got;
        i0 = del_q.size(); w0 = wv_q.size(); inc0 = incr_cnt; s0 = samp_cnt;
        cmd_dest_i = 7'h7F; cmd_error_i = 1'b1; cmd_id_i = 16'h2A; cmd_user_i = 6'd5;
        cmd_valid_i = 1'b1;
        #1;
        n_vec++; if (incr_req_o !== 1'b0) begin n_err++; $display("FAIL decerr_incr: got %b exp 0", incr_req_o); end
        step();
        cmd_valid_i = 1'b0; cmd_error_i = 1'b0;
        drive_burst(2, 64'h300, 20, got);
        n_vec++; if (got !== 2) begin n_err++; $display("FAIL decerr_sunk: got %0d exp 2", got); end
        n_vec++; if (wv_q.size() !== w0 || del_q.size() !== i0) begin
            n_err++; $display("FAIL decerr_forwarded: got %0d valid cycles exp 0", wv_q.size() - w0); end
        n_vec++; if (samp_cnt - s0 !== 1) begin n_err++; $display("FAIL decerr_sample_count: got %0d exp 1", samp_cnt - s0); end
        n_vec++; if (incr_cnt - inc0 !== 0) begin n_err++; $display("FAIL decerr_incr_count: got %0d exp 0", incr_cnt - inc0); end
        n_vec++; if (error_req_o !== 1'b1) begin n_err++; $display("FAIL decerr_req: got %b exp 1", error_req_o); end
        n_vec++; if ({error_id_o, error_user_o} !== {16'h2A, 6'd5}) begin
            n_err++; $display("FAIL decerr_info: got %h/%h exp 002a/05", error_id_o, error_user_o); end
        step(); step();
        n_vec++; if (error_req_o !== 1'b1) begin n_err++; $display("FAIL decerr_req_hold: got %b exp 1", error_req_o); end
        error_gnt_i = 1'b1;
        #1;
        n_vec++; if (error_req_o !== 1'b0) begin n_err++; $display("FAIL decerr_req_at_gnt: got %b exp 0", error_req_o); end
        step();
        n_vec++; if ({error_req_o, error_id_o} !== {1'b0, 16'h2A}) begin
            n_err++; $display("FAIL decerr_wait: got req %b id %h exp 0/002a", error_req_o, error_id_o); end
        error_gnt_i = 1'b0;
        step(); step();
    endtask

    task automatic test_full();
        int w0, inc0, got;
        inc0 = incr_cnt;
        for (int k = 0; k < 4; k++) begin
            cmd_dest_i = N'(1 << k); cmd_error_i = 1'b0; cmd_id_i = IW'(10 + k); cmd_valid_i = 1'b1;
            #1;
            n_vec++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL full_fill%0d_ready: got %b exp 1", k, cmd_ready_o); end
            step();
        end
        cmd_dest_i = 7'h40;
        #1;
        n_vec++; if ({cmd_ready_o, incr_req_o} !== 2'b00) begin
            n_err++; $display("FAIL full_refuse: got ready/incr %b exp 00", {cmd_ready_o, incr_req_o}); end
        wvalid_i = 1'b1; wlast_i = 1'b1; wdata_i = 64'h400;
        #1;
        n_vec++; if ({wready_o, cmd_ready_o, incr_req_o} !== 3'b100) begin
            n_err++; $display("FAIL full_pop_push: got wready/ready/incr %b exp 100", {wready_o, cmd_ready_o, incr_req_o}); end
        step();
        cmd_valid_i = 1'b0; wvalid_i = 1'b0; wlast_i = 1'b0;
        #1;
        n_vec++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL full_after_pop: got %b exp 1", cmd_ready_o); end
        full_counter_i = 1'b1; cmd_valid_i = 1'b1;
        #1;
        n_vec++; if ({cmd_ready_o, incr_req_o} !== 2'b00) begin
            n_err++; $display("FAIL full_counter_block: got ready/incr %b exp 00", {cmd_ready_o, incr_req_o}); end
        step();
        full_counter_i = 1'b0; cmd_valid_i = 1'b0;
        w0 = wv_q.size();
        for (int k = 1; k < 4; k++) begin
            drive_burst(1, 64'h410 + DW'(k), 20, got);
            n_vec++; if (got !== 1) begin n_err++; $display("FAIL full_drain%0d: got %0d exp 1", k, got); end
        end
        n_vec++; if (wv_q.size() - w0 !== 3) begin n_err++; $display("FAIL full_drain_cycles: got %0d exp 3", wv_q.size() - w0); end
        for (int k = 0; k < 3 && w0 + k < wv_q.size(); k++) begin
            n_vec++; if (wv_q[w0+k] !== N'(2 << k)) begin
                n_err++; $display("FAIL full_order%0d: got %b exp %b", k, wv_q[w0+k], N'(2 << k)); end
        end
        n_vec++; if (incr_cnt - inc0 !== 4) begin n_err++; $display("FAIL full_incr_count: got %0d exp 4", incr_cnt - inc0); end
        step();
    endtask

    task automatic test_mixed();
        int w0, a0, got;
        w0 = wv_q.size();
        push_cmd(7'h20, 1'b0, 16'd20, 6'd1);
        push_cmd(7'h00, 1'b1, 16'd21, 6'd2);
        push_cmd(7'h40, 1'b0, 16'd22, 6'd3);
        drive_burst(2, 64'h500, 20, got);
        n_vec++; if (got !== 2) begin n_err++; $display("FAIL mixed_first: got %0d exp 2", got); end
        drive_burst(1, 64'h600, 20, got);
        n_vec++; if (got !== 1) begin n_err++; $display("FAIL mixed_error: got %0d exp 1", got); end
        a0 = acc_cnt;
        wvalid_i = 1'b1; wdata_i = 64'h700; wlast_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_vec++; if ({wready_o, error_req_o} !== 2'b01) begin
                n_err++; $display("FAIL mixed_hold%0d: got wready/req %b exp 01", c, {wready_o, error_req_o}); end
            step();
        end
        error_gnt_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++; if ({wready_o, error_req_o} !== 2'b00) begin
                n_err++; $display("FAIL mixed_gnt%0d: got wready/req %b exp 00", c, {wready_o, error_req_o}); end
            step();
        end
        n_vec++; if (acc_cnt !== a0) begin n_err++; $display("FAIL mixed_blocked_beats: got %0d exp 0", acc_cnt - a0); end
        error_gnt_i = 1'b0;
        drive_burst(3, 64'h700, 20, got);
        n_vec++; if (got !== 3) begin n_err++; $display("FAIL mixed_third: got %0d exp 3", got); end
        n_vec++; if (wv_q.size() - w0 !== 5) begin n_err++; $display("FAIL mixed_valid_cycles: got %0d exp 5", wv_q.size() - w0); end
        for (int k = 0; k < 5 && w0 + k < wv_q.size(); k++) begin
            n_vec++; if (wv_q[w0+k] !== ((k < 2) ? 7'h20 : 7'h40)) begin
                n_err++; $display("FAIL mixed_port%0d: got %b", k, wv_q[w0+k]); end
        end
        step();
    endtask

    task automatic test_reset_mid();
        int w0, got;
        push_cmd(7'h01, 1'b0, 16'd30, 6'd0);
        wvalid_i = 1'b1; wlast_i = 1'b0; wdata_i = 64'h800;
        step();
        n_vec++; if (wready_o !== 1'b1) begin n_err++; $display("FAIL midrst_fwd: got %b exp 1", wready_o); end
        step();
        rst_n = 1'b0; cmd_valid_i = 1'b1; cmd_dest_i = 7'h02;
        #1;
        n_vec++; if ({wvalid_o, wready_o, cmd_ready_o, incr_req_o, error_req_o, sample_awdata_info_o} !== 12'h000) begin
            n_err++; $display("FAIL midrst_outputs: got %h exp 000",
                {wvalid_o, wready_o, cmd_ready_o, incr_req_o, error_req_o, sample_awdata_info_o}); end
        step(); step();
        rst_n = 1'b1; cmd_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if ({wvalid_o, wready_o} !== 8'h00) begin
                n_err++; $display("FAIL midrst_flushed%0d: got %h exp 00", c, {wvalid_o, wready_o}); end
            step();
        end
        wvalid_i = 1'b0;
        w0 = wv_q.size();
        push_cmd(7'h08, 1'b0, 16'd31, 6'd0);
        drive_burst(2, 64'h900, 20, got);
        n_vec++; if (got !== 2) begin n_err++; $display("FAIL midrst_recover: got %0d exp 2", got); end
        n_vec++; if (wv_q.size() - w0 !== 2 || wv_q[wv_q.size()-1] !== 7'h08) begin
            n_err++; $display("FAIL midrst_port: got %0d cycles last %b exp 2/0001000", wv_q.size() - w0, wv_q[wv_q.size()-1]); end
    endtask

    initial begin
        test_reset();
        test_route();
        test_backpressure();
        test_decerr();
        test_full();
        test_mixed();
        test_reset_mid();
        step();
        n_vec++; if (viol_cnt !== 0) begin n_err++; $display("FAIL req_during_gnt: got %0d cycles exp 0", viol_cnt); end
        n_vec++; if (bad_samp !== 0) begin n_err++; $display("FAIL sample_off_last: got %0d pulses exp 0", bad_samp); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
